spinner_quad_encoder: RTL



---
 rtl/spinner_pkg.sv | 37 +++
 rtl/spinner_quad_encoder_channel.sv | 145 ++++++++++++++
 rtl/spinner_quad_encoder.sv | 71 +++++++
 3 files changed

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner quadrature emulator.
package spinner_pkg;

    typedef enum logic [1:0] {
        TIMED  = 2'd0,
        HIRES  = 2'd1,
        MEDRES = 2'd2,
        LORES  = 2'd3
    } btn_mode_t;

    localparam logic [1:0] ENC_RST    = 2'b11;
    localparam int         TIMED_FAST = 9;
    localparam int         TIMED_SLOW = 4;

    // dir=1 walks the positive sequence 00->10->11->01, dir=0 the reverse
    function automatic logic [1:0] quad_next(input logic [1:0] enc, input logic dir);
        logic [1:0] n;
        n = 2'b00;
        if (dir) begin
            case (enc)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end else begin
            case (enc)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/spinner_quad_encoder_channel.sv
// One spinner channel: step accumulator, button repeat, encoder passthrough.
module spinner_channel
    import spinner_pkg::*;
#(
    parameter int POS_W    = 12,
    parameter int DELTA_W  = 9,
    parameter int HOLD_DIV = 48000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               tick,
    input  logic               delta_valid,
    input  logic [DELTA_W-1:0] delta,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fast,
    input  logic [1:0]         btn_mode,
    input  logic [1:0]         ext_quad,
    output logic [1:0]         quad_out,
    output logic               ext_active,
    output logic               busy
);

    localparam int HOLD_W = $clog2(HOLD_DIV + 1);
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] NEG_MAX = {1'b1, {(POS_W-2){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] MIN_VAL = {1'b1, {(POS_W-1){1'b0}}};

    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [1:0]              enc_q, enc_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [1:0]              sync1_q, sync2_q, prev_q;
    logic                    ext_active_q, ext_active_d;
    logic [1:0]              quad_out_q, quad_out_d;

    btn_mode_t          mode;
    logic               btn_any;
    logic [POS_W-1:0]   dx;
    logic [POS_W:0]     sum;
    logic [POS_W-1:0]   sat;
    logic [POS_W-1:0]   mag;
    logic [1:0]         sh;
    logic               keep;
    logic               btn_set;

    assign mode    = btn_mode_t'(btn_mode);
    assign btn_any = btn_left | btn_right;
    assign dx      = {{(POS_W-DELTA_W){delta[DELTA_W-1]}}, delta};

    always_comb begin
        sum  = {pos_q[POS_W-1], pos_q} + {dx[POS_W-1], dx};
        keep = (pos_q == '0) || (dx == '0) || (pos_q[POS_W-1] == dx[POS_W-1]);
        // saturate symmetrically; the most negative code is never produced
        if (sum[POS_W] != sum[POS_W-1]) begin
            sat = sum[POS_W] ? NEG_MAX : POS_MAX;
        end else if (sum[POS_W-1:0] == MIN_VAL) begin
            sat = NEG_MAX;
        end else begin
            sat = sum[POS_W-1:0];
        end
    end

    always_comb begin
        sh  = btn_mode - {1'b0, ~btn_fast};
        mag = {{(POS_W-2){1'b0}}, 2'b10} << sh;
        if (mode == TIMED) begin
            mag = btn_fast ? POS_W'(TIMED_FAST) : POS_W'(TIMED_SLOW);
        end
    end

    always_comb begin
        pos_d        = pos_q;
        enc_d        = enc_q;
        hold_d       = hold_q;
        ext_active_d = ext_active_q;
        btn_set      = 1'b0;

        if (tick && pos_q != '0) begin
            enc_d = quad_next(enc_q, ~pos_q[POS_W-1]);
            pos_d = pos_q[POS_W-1] ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end

        if (delta_valid) begin
            pos_d        = keep ? sat : dx;
            ext_active_d = 1'b0;
        end

        if (ce) begin
            if (btn_any) begin
                ext_active_d = 1'b0;
            end
            if (mode == TIMED && btn_any) begin
                if (hold_q == HOLD_W'(HOLD_DIV - 1)) begin
                    hold_d  = '0;
                    btn_set = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end else begin
                hold_d = '0;
            end
            if (mode != TIMED && btn_any) begin
                btn_set = 1'b1;
            end
        end

        if (btn_set) begin
            pos_d = btn_right ? mag : POS_W'(0) - mag;
        end

        if (sync2_q != prev_q) begin
            ext_active_d = 1'b1;
        end

        quad_out_d = ext_active_d ? sync2_q : enc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= '0;
            enc_q        <= ENC_RST;
            hold_q       <= '0;
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            prev_q       <= 2'b11;
            ext_active_q <= 1'b0;
            quad_out_q   <= 2'b11;
        end else begin
            pos_q        <= pos_d;
            enc_q        <= enc_d;
            hold_q       <= hold_d;
            sync1_q      <= ext_quad;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            ext_active_q <= ext_active_d;
            quad_out_q   <= quad_out_d;
        end
    end

    assign quad_out   = quad_out_q;
    assign ext_active = ext_active_q;
    assign busy       = (pos_q != '0);

endmodule

// File: rtl/spinner_quad_encoder.sv
// Multi-channel spinner emulator: shared step divider plus per-channel slices.
module spinner_quad_encoder
    import spinner_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int POS_W    = 12,
    parameter int DELTA_W  = 9,
    parameter int STEP_DIV = 1500,
    parameter int HOLD_DIV = 48000
) (
    input  logic                        clk_12m,
    input  logic                        reset,
    input  logic                        ce,
    input  logic [CHANNELS-1:0]         delta_valid,
    input  logic [CHANNELS*DELTA_W-1:0] delta,
    input  logic [CHANNELS-1:0]         btn_left,
    input  logic [CHANNELS-1:0]         btn_right,
    input  logic [CHANNELS-1:0]         btn_fast,
    input  logic [1:0]                  btn_mode,
    input  logic [2*CHANNELS-1:0]       ext_quad,
    output logic [2*CHANNELS-1:0]       quad_out,
    output logic [CHANNELS-1:0]         ext_active,
    output logic [CHANNELS-1:0]         busy
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        div_d = div_q;
        if (ce) begin
            div_d = (div_q == DIV_W'(STEP_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_12m or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = ce && (div_q == '0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spinner_channel #(
            .POS_W   (POS_W),
            .DELTA_W (DELTA_W),
            .HOLD_DIV(HOLD_DIV)
        ) u_ch (
            .clk        (clk_12m),
            .rst_n      (reset),
            .ce         (ce),
            .tick       (tick),
            .delta_valid(delta_valid[i]),
            .delta      (delta[i*DELTA_W +: DELTA_W]),
            .btn_left   (btn_left[i]),
            .btn_right  (btn_right[i]),
            .btn_fast   (btn_fast[i]),
            .btn_mode   (btn_mode),
            .ext_quad   (ext_quad[2*i +: 2]),
            .quad_out   (quad_out[2*i +: 2]),
            .ext_active (ext_active[i]),
            .busy       (busy[i])
        );
    end

endmodule
